fp16_mul_seq: RTL



---
 rtl/fp16_mul_seq.sv | 302 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fp16_mul_seq.sv
// fp16_mul_seq: multi-cycle IEEE-754 binary16 multiplier (11-step shift-add, round-to-nearest-even).
// Optional macro FP16_SUBNORMAL_EN adds subnormal operands/results; otherwise they flush to signed zero.
module fp16_mul_seq (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic [15:0] OP_A_HALF,
    input  logic [15:0] OP_B_HALF,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] RESULT_HALF,
    output logic [2:0]  EXC_FLAGS
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        MULT   = 3'd2,
        NORM   = 3'd3,
        ROUND  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        op_a_q, op_a_d;
    logic [15:0]        op_b_q, op_b_d;
    logic [21:0]        acc_q, acc_d;
    logic [3:0]         cnt_q, cnt_d;
    logic signed [6:0]  exp_q, exp_d;
    logic [9:0]         mant_q, mant_d;
    logic               guard_q, guard_d;
    logic               sticky_q, sticky_d;
    logic               special_q, special_d;
    logic [15:0]        spec_res_q, spec_res_d;
    logic [2:0]         spec_flags_q, spec_flags_d;
    logic [15:0]        result_q, result_d;
    logic [2:0]         flags_q, flags_d;
    logic               done_q, done_d;
`ifdef FP16_SUBNORMAL_EN
    logic               tiny_q, tiny_d;
`endif

    // Operand fields, taken straight from the captured operands.
    logic [4:0]  exp_a, exp_b;
    logic [9:0]  man_a, man_b;
    logic [10:0] sig_a, sig_b;
    logic [4:0]  eff_exp_a, eff_exp_b;
    logic        res_sign;
    logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

    assign exp_a    = op_a_q[14:10];
    assign exp_b    = op_b_q[14:10];
    assign man_a    = op_a_q[9:0];
    assign man_b    = op_b_q[9:0];
    assign sig_a    = {|exp_a, man_a};
    assign sig_b    = {|exp_b, man_b};
    assign res_sign = op_a_q[15] ^ op_b_q[15];
    assign nan_a    = (&exp_a) & (|man_a);
    assign nan_b    = (&exp_b) & (|man_b);
    assign inf_a    = (&exp_a) & ~(|man_a);
    assign inf_b    = (&exp_b) & ~(|man_b);

`ifdef FP16_SUBNORMAL_EN
    assign zero_a    = ~(|exp_a) & ~(|man_a);
    assign zero_b    = ~(|exp_b) & ~(|man_b);
    assign eff_exp_a = (|exp_a) ? exp_a : 5'd1;
    assign eff_exp_b = (|exp_b) ? exp_b : 5'd1;
`else
    // Subnormal operands count as zero and take the special-case path.
    assign zero_a    = ~(|exp_a);
    assign zero_b    = ~(|exp_b);
    assign eff_exp_a = exp_a;
    assign eff_exp_b = exp_b;
`endif

    // Normalization of the raw product held in acc_q.
    logic signed [6:0] exp_sum;
    logic signed [6:0] norm_exp;
    logic [9:0]        norm_mant;
    logic              norm_guard;
    logic              norm_sticky;
`ifdef FP16_SUBNORMAL_EN
    logic              norm_tiny;
    logic [20:0]       norm_sig;
    logic              norm_extra;
    logic [4:0]        lz;
    logic signed [6:0] shift_full;
    logic [4:0]        shift_amt;
    logic [51:0]       shifted;

    function automatic logic [4:0] lzc21(input logic [20:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i <= 20; i++) begin
            if (v[i]) n = 5'(20 - i);
        end
        return n;
    endfunction
`endif

    assign exp_sum = $signed({2'b00, eff_exp_a}) + $signed({2'b00, eff_exp_b}) - 7'sd15;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        norm_exp    = exp_sum;
        norm_mant   = 10'd0;
        norm_guard  = 1'b0;
        norm_sticky = 1'b0;
`ifdef FP16_SUBNORMAL_EN
        norm_tiny  = 1'b0;
        norm_extra = 1'b0;
        lz         = 5'd0;
        shift_amt  = 5'd0;
        if (acc_q[21]) begin
            norm_sig   = acc_q[21:1];
            norm_extra = acc_q[0];
            norm_exp   = exp_sum + 7'sd1;
        end else begin
            lz       = lzc21(acc_q[20:0]);
            norm_sig = acc_q[20:0] << lz;
            norm_exp = exp_sum - $signed({2'b00, lz});
        end
        // Tiny results are denormalized; shifts past 31 only feed sticky anyway.
        shift_full = 7'sd1 - norm_exp;
        if (norm_exp <= 7'sd0) begin
            norm_tiny = 1'b1;
            shift_amt = (shift_full > 7'sd31) ? 5'd31 : shift_full[4:0];
            norm_exp  = 7'sd0;
        end
        shifted     = 52'({norm_sig, 32'd0} >> shift_amt);
        norm_mant   = shifted[51:42];
        norm_guard  = shifted[41];
        norm_sticky = (|shifted[40:0]) | norm_extra;
`else
        if (acc_q[21]) begin
            norm_mant   = acc_q[20:11];
            norm_guard  = acc_q[10];
            norm_sticky = |acc_q[9:0];
            norm_exp    = exp_sum + 7'sd1;
        end else begin
            norm_mant   = acc_q[19:10];
            norm_guard  = acc_q[9];
            norm_sticky = |acc_q[8:0];
        end
`endif
    end

    // Rounding: a carry out of the mantissa bumps the exponent.
    logic              round_up;
    logic [10:0]       rnd_mant;
    logic signed [6:0] rnd_exp;

    assign round_up = guard_q & (sticky_q | mant_q[0]);
    assign rnd_mant = {1'b0, mant_q} + {10'd0, round_up};
    assign rnd_exp  = exp_q + $signed({6'd0, rnd_mant[10]});

    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        exp_d        = exp_q;
        mant_d       = mant_q;
        guard_d      = guard_q;
        sticky_d     = sticky_q;
        special_d    = special_q;
        spec_res_d   = spec_res_q;
        spec_flags_d = spec_flags_q;
        result_d     = result_q;
        flags_d      = flags_q;
        done_d       = 1'b0;
`ifdef FP16_SUBNORMAL_EN
        tiny_d       = tiny_q;
`endif

        case (state_q)
            IDLE: begin
                if (START) begin
                    op_a_d  = OP_A_HALF;
                    op_b_d  = OP_B_HALF;
                    state_d = DECODE;
                end
            end

            DECODE: begin
                special_d    = 1'b1;
                spec_flags_d = 3'b000;
                spec_res_d   = {res_sign, 15'h0000};
                state_d      = ROUND;
                if (nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a)) begin
                    spec_res_d   = 16'h7E00;
                    spec_flags_d = 3'b100;
                end else if (inf_a | inf_b) begin
                    spec_res_d = {res_sign, 15'h7C00};
                end else if (!(zero_a | zero_b)) begin
                    special_d = 1'b0;
                    acc_d     = 22'd0;
                    cnt_d     = 4'd0;
                    state_d   = MULT;
                end
            end

            MULT: begin
                if (sig_b[cnt_q]) begin
                    acc_d = acc_q + ({11'd0, sig_a} << cnt_q);
                end
                if (cnt_q == 4'd10) begin
                    state_d = NORM;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            NORM: begin
                exp_d    = norm_exp;
                mant_d   = norm_mant;
                guard_d  = norm_guard;
                sticky_d = norm_sticky;
`ifdef FP16_SUBNORMAL_EN
                tiny_d   = norm_tiny;
`endif
                state_d  = ROUND;
            end

            ROUND: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (special_q) begin
                    result_d = spec_res_q;
                    flags_d  = spec_flags_q;
                end else if (rnd_exp >= 7'sd31) begin
                    result_d = {res_sign, 5'h1F, 10'h000};
                    flags_d  = 3'b010;
`ifdef FP16_SUBNORMAL_EN
                end else begin
                    result_d = {res_sign, rnd_exp[4:0], rnd_mant[9:0]};
                    flags_d  = {2'b00, tiny_q & (guard_q | sticky_q)};
                end
`else
                end else if (rnd_exp <= 7'sd0) begin
                    result_d = {res_sign, 15'h0000};
                    flags_d  = 3'b001;
                end else begin
                    result_d = {res_sign, rnd_exp[4:0], rnd_mant[9:0]};
                    flags_d  = 3'b000;
                end
`endif
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            op_a_q       <= 16'h0000;
            op_b_q       <= 16'h0000;
            acc_q        <= 22'd0;
            cnt_q        <= 4'd0;
            exp_q        <= 7'sd0;
            mant_q       <= 10'd0;
            guard_q      <= 1'b0;
            sticky_q     <= 1'b0;
            special_q    <= 1'b0;
            spec_res_q   <= 16'h0000;
            spec_flags_q <= 3'b000;
            result_q     <= 16'h0000;
            flags_q      <= 3'b000;
            done_q       <= 1'b0;
`ifdef FP16_SUBNORMAL_EN
            tiny_q       <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            exp_q        <= exp_d;
            mant_q       <= mant_d;
            guard_q      <= guard_d;
            sticky_q     <= sticky_d;
            special_q    <= special_d;
            spec_res_q   <= spec_res_d;
            spec_flags_q <= spec_flags_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
            done_q       <= done_d;
`ifdef FP16_SUBNORMAL_EN
            tiny_q       <= tiny_d;
`endif
        end
    end

    assign BUSY        = (state_q != IDLE);
    assign DONE        = done_q;
    assign RESULT_HALF = result_q;
    assign EXC_FLAGS   = flags_q;

endmodule
